// File: rtl/noc_inject_ni_if.sv
// Local-PE <-> NI <-> router handshake bundle: packet request, payload stream, flit port.
// The NI uses the slave modport; the PE/router side uses master.
interface noc_inject_ni_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [4:0]            req_dest_x;
  logic [4:0]            req_dest_y;
  logic [LEN_W-1:0]      req_len;
  logic [DATA_WIDTH-1:0] pl_data;
  logic                  pl_valid;
  logic                  pl_ready;
  logic [DATA_WIDTH-1:0] flit_data;
  logic                  flit_valid;
  logic                  flit_ready;

  modport master (
    output req_valid, req_dest_x, req_dest_y, req_len, pl_data, pl_valid, flit_ready,
    input  req_ready, pl_ready, flit_data, flit_valid
  );

  modport slave (
    input  req_valid, req_dest_x, req_dest_y, req_len, pl_data, pl_valid, flit_ready,
    output req_ready, pl_ready, flit_data, flit_valid
  );
endinterface

// File: rtl/noc_inject_ni.sv
// Injection NI: header flit then FIFO-buffered payload flits into one mesh router port.
// Define NI_HDR_PARITY_EN to put even parity over header bits [23:0] in the header MSB.
module noc_inject_ni #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [4:0]     i_node_x,
  input  logic [4:0]     i_node_y,
  noc_inject_ni_if.slave bus,
  output logic           o_busy,
  output logic [15:0]    o_pkt_count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, PAYLOAD} state_e;

  state_e                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wptr, r_rptr;
  logic [LEN_W-1:0]      r_rem, w_rem_nxt;
  logic [DATA_WIDTH-1:0] r_flit, w_flit_nxt, w_hdr;
  logic                  r_vld, w_vld_nxt, r_last, w_last_nxt;
  logic [15:0]           r_pkt_cnt;
  logic                  w_full, w_empty, w_push, w_pop;
  logic                  w_free, w_xfer, w_req_ready, w_req_fire;
  logic [3:0]            w_len4;

  // Extra pointer MSB distinguishes full from empty.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = bus.pl_valid && !w_full;

  assign w_free = !r_vld || bus.flit_ready;
  assign w_xfer = r_vld && bus.flit_ready;
  // rem==0 in PAYLOAD means the last flit is on the port; accept the next request as it leaves.
  assign w_req_ready = w_free && ((r_state == IDLE) || (r_rem == '0));
  assign w_req_fire  = bus.req_valid && w_req_ready;
  assign w_pop       = (r_state == PAYLOAD) && w_free && (r_rem != '0) && !w_empty;

  assign w_len4 = 4'(bus.req_len);

  always_comb begin
    w_hdr        = '0;
    w_hdr[4:0]   = bus.req_dest_y;
    w_hdr[9:5]   = bus.req_dest_x;
    w_hdr[13:10] = w_len4;
    w_hdr[18:14] = i_node_x;
    w_hdr[23:19] = i_node_y;
`ifdef NI_HDR_PARITY_EN
    w_hdr[DATA_WIDTH-1] = ^w_hdr[23:0];
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_flit_nxt  = r_flit;
    w_vld_nxt   = r_vld;
    w_last_nxt  = r_last;
    if (w_req_fire) begin
      w_flit_nxt  = w_hdr;
      w_vld_nxt   = 1'b1;
      w_rem_nxt   = bus.req_len;
      w_last_nxt  = (bus.req_len == '0);
      w_state_nxt = (bus.req_len == '0) ? IDLE : PAYLOAD;
    end else if (w_pop) begin
      w_flit_nxt = r_mem[r_rptr[AW-1:0]];
      w_vld_nxt  = 1'b1;
      w_rem_nxt  = r_rem - LEN_W'(1);
      w_last_nxt = (r_rem == LEN_W'(1));
    end else begin
      if (w_free) w_vld_nxt = 1'b0;
      if ((r_state == PAYLOAD) && (r_rem == '0) && w_xfer) w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_flit    <= '0;
      r_vld     <= 1'b0;
      r_last    <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_flit  <= w_flit_nxt;
      r_vld   <= w_vld_nxt;
      r_last  <= w_last_nxt;
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      if (w_xfer && r_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.pl_data;
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.pl_ready   = !w_full;
  assign bus.flit_data  = r_flit;
  assign bus.flit_valid = r_vld;
  assign o_busy         = (r_state != IDLE) || r_vld;
  assign o_pkt_count    = r_pkt_cnt;
endmodule

// File: tb/tb_noc_inject_ni.sv
// Directed scenarios plus randomized traffic, checked against a queue-based packet model.
module tb_noc_inject_ni;
  localparam int DW = 32, FD = 4, LW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  node_x = '0, node_y = '0;
  logic        busy;
  logic [15:0] pkt_count;
  int          n_err = 0, n_chk = 0;

  noc_inject_ni_if #(.DATA_WIDTH(DW), .LEN_W(LW)) bus();

  noc_inject_ni #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .i_node_x(node_x), .i_node_y(node_y),
    .bus(bus), .o_busy(busy), .o_pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Header from field arithmetic: ny*2^19 + nx*2^14 + len*2^10 + dx*2^5 + dy.
  function automatic logic [31:0] hdr_f(input int nx, input int ny, input int dx,
                                        input int dy, input int len);
    logic [31:0] h;
    h = 32'(ny * (1 << 19) + nx * (1 << 14) + len * (1 << 10) + dx * 32 + dy);
`ifdef NI_HDR_PARITY_EN
    if (($countones(h[23:0]) % 2) == 1) h[31] = 1'b1;
`endif
    return h;
  endfunction

  // Reference model: expected headers in request order, payload words in push order.
  logic [31:0] hq[$];
  int          lq[$];
  logic [31:0] pq[$];
  int          m_rem = 0;
  bit          m_inpkt = 0;
  logic [15:0] m_cnt = '0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hq.delete(); lq.delete(); pq.delete();
      m_rem = 0; m_inpkt = 0; m_cnt = '0; prev_stall = 0;
    end else begin
      chk("pkt_count", pkt_count, m_cnt);
      if (prev_stall) begin
        chk("hold_vld", bus.flit_valid, 1'b1);
        chk("hold_data", bus.flit_data, prev_data);
      end
      prev_stall = bus.flit_valid && !bus.flit_ready;
      prev_data  = bus.flit_data;
      if (bus.pl_valid && bus.pl_ready) pq.push_back(bus.pl_data);
      if (bus.req_valid && bus.req_ready) begin
        hq.push_back(hdr_f(node_x, node_y, bus.req_dest_x, bus.req_dest_y, bus.req_len));
        lq.push_back(int'(bus.req_len));
      end
      if (bus.flit_valid && bus.flit_ready) begin
        if (!m_inpkt) begin
          chk("hdr_avail", 32'(hq.size() > 0), 1);
          if (hq.size() > 0) begin
            chk("hdr", bus.flit_data, hq.pop_front());
            m_rem = lq.pop_front();
            if (m_rem == 0) m_cnt++;
            else m_inpkt = 1;
          end
        end else begin
          chk("pl_avail", 32'(pq.size() > 0), 1);
          if (pq.size() > 0) chk("payload", bus.flit_data, pq.pop_front());
          m_rem--;
          if (m_rem == 0) begin
            m_inpkt = 0;
            m_cnt++;
          end
        end
      end
    end
  end

  initial begin
    bit fired;
    int t;
    bus.req_valid = 0; bus.req_dest_x = '0; bus.req_dest_y = '0; bus.req_len = '0;
    bus.pl_valid = 0; bus.pl_data = '0; bus.flit_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", bus.flit_valid, 0);
    chk("rst_data", bus.flit_data, 0);
    chk("rst_cnt", pkt_count, 0);
    chk("rst_plrdy", bus.pl_ready, 1);
    chk("rst_busy", busy, 0);
    tick(); rst_n = 1'b1; tick();

    // Two prefilled words, then a len=2 packet at full rate.
    node_x = 5'd1; node_y = 5'd2;
    bus.pl_valid = 1; bus.pl_data = 32'hAAAA_0001; tick();
    bus.pl_data = 32'hBBBB_0002; tick();
    bus.pl_valid = 0;
    bus.req_valid = 1; bus.req_dest_x = 5'd3; bus.req_dest_y = 5'd4; bus.req_len = 4'd2;
    #1 chk("s1_req_rdy", bus.req_ready, 1);
    tick(); bus.req_valid = 0;
    chk("s1_hdr_vld", bus.flit_valid, 1);
    chk("s1_hdr", bus.flit_data, hdr_f(1, 2, 3, 4, 2));
    tick(); chk("s1_A", bus.flit_data, 32'hAAAA_0001); chk("s1_A_vld", bus.flit_valid, 1);
    tick(); chk("s1_B", bus.flit_data, 32'hBBBB_0002); chk("s1_B_vld", bus.flit_valid, 1);
    tick(); chk("s1_idle_vld", bus.flit_valid, 0); chk("s1_cnt", pkt_count, 1);

    // Header-only packet.
    node_x = '0; node_y = '0;
    bus.req_valid = 1; bus.req_dest_x = '0; bus.req_dest_y = '0; bus.req_len = '0;
    #1 chk("s2_req_rdy", bus.req_ready, 1);
    tick(); bus.req_valid = 0;
    chk("s2_hdr", bus.flit_data, hdr_f(0, 0, 0, 0, 0)); chk("s2_vld", bus.flit_valid, 1);
    tick(); chk("s2_cnt", pkt_count, 2); chk("s2_vld0", bus.flit_valid, 0);
    #1 chk("s2_req_rdy2", bus.req_ready, 1);

    // Fill the FIFO with no request pending; 5th word must wait for a pop.
    for (int i = 0; i < 5; i++) begin
      bus.pl_valid = 1; bus.pl_data = 32'h4000 + 32'(i);
      #1 chk("s4_plrdy", bus.pl_ready, 32'(i < FD));
      tick();
    end
    chk("s4_full", bus.pl_ready, 0);
    bus.req_valid = 1; bus.req_dest_x = 5'd5; bus.req_dest_y = 5'd6; bus.req_len = 4'd1;
    tick(); bus.req_valid = 0;
    chk("s4_full_pop", bus.pl_ready, 0);
    tick(); chk("s4_after_pop", bus.pl_ready, 1);
    tick(); bus.pl_valid = 0;

    // Reset in the middle of a len=5 packet.
    bus.req_valid = 1; bus.req_dest_x = 5'd1; bus.req_dest_y = 5'd1; bus.req_len = 4'd5;
    tick(); bus.req_valid = 0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("s6_vld", bus.flit_valid, 0);
    chk("s6_cnt", pkt_count, 0);
    chk("s6_empty", bus.pl_ready, 1);
    chk("s6_busy", busy, 0);
    tick(); rst_n = 1'b1; tick();
    bus.pl_valid = 1; bus.pl_data = 32'h6000_0001; tick(); bus.pl_valid = 0;
    bus.req_valid = 1; bus.req_dest_x = 5'd2; bus.req_dest_y = 5'd3; bus.req_len = 4'd1;
    tick(); bus.req_valid = 0;
    repeat (3) tick();
    chk("s6_fresh_cnt", pkt_count, 1);
    chk("s6_fresh_busy", busy, 0);

    // Random traffic: payload gaps, router stalls, back-to-back requests.
    node_x = 5'($urandom); node_y = 5'($urandom);
    fired = 0;
    for (int c = 0; c < 3000; c++) begin
      if (fired || !bus.req_valid) begin
        bus.req_valid  = ($urandom_range(0, 5) == 0);
        bus.req_dest_x = 5'($urandom);
        bus.req_dest_y = 5'($urandom);
        bus.req_len    = 4'($urandom);
      end
      bus.pl_valid   = $urandom_range(0, 1) == 1;
      bus.pl_data    = $urandom;
      bus.flit_ready = ($urandom_range(0, 3) != 0);
      #1 fired = bus.req_valid && bus.req_ready;
      tick();
    end

    bus.req_valid = 0; bus.pl_valid = 1; bus.flit_ready = 1;
    t = 0;
    while (busy && t < 500) begin
      bus.pl_data = $urandom;
      tick();
      t++;
    end
    chk("drain_busy", busy, 0);
    bus.pl_valid = 0;
    tick(); tick();
    chk("final_cnt", pkt_count, m_cnt);
    chk("final_hq", hq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
